// File: rtl/fetch_seq.sv
// ============================================================================
// fetch_seq -- PC sequencer with branch/exception redirect and shared SPR port
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_0700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        ctr_we_req_i,
  input  logic [31:0] ctr_wd_i,
  input  logic        lr_we_req_i,
  input  logic [31:0] lr_wd_i,
  input  logic        exc_req_i,
  output logic [31:0] pc_o,
  output logic        fetch_en_o,
  output logic        flush_o,
  output logic        spr_we_o,
  output logic        spr_sel_o,
  output logic [31:0] spr_wd_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        lr_pend_q, lr_pend_d;
  logic [31:0] lr_data_q, lr_data_d;
  logic        flush_q, flush_d;
  logic        spr_we_q, spr_we_d;
  logic        spr_sel_q, spr_sel_d;
  logic [31:0] spr_wd_q, spr_wd_d;
  logic        busy_w;
  logic        accept_w;

  assign busy_w   = (state_q != RUN) | lr_pend_q;
  assign accept_w = br_valid_i & ~busy_w;

  assign pc_o       = pc_q;
  assign flush_o    = flush_q;
  assign spr_we_o   = spr_we_q;
  assign spr_sel_o  = spr_sel_q;
  assign spr_wd_o   = spr_wd_q;
  assign busy_o     = busy_w & ~rst;
  assign fetch_en_o = (state_q == RUN) & ~lr_pend_q & ~stall_i & ~rst;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    lr_pend_d = 1'b0;
    lr_data_d = lr_data_q;
    flush_d   = 1'b0;
    spr_we_d  = 1'b0;
    spr_sel_d = spr_sel_q;
    spr_wd_d  = spr_wd_q;

    if (exc_req_i) begin
      pc_d    = EXC_VEC;
      flush_d = 1'b1;
      state_d = FLUSH;
    end else if (accept_w) begin
      // Dual request: CTR goes out now, LR is parked for the following cycle.
      if (ctr_we_req_i && lr_we_req_i) begin
        spr_we_d  = 1'b1;
        spr_sel_d = 1'b0;
        spr_wd_d  = ctr_wd_i;
        lr_pend_d = 1'b1;
        lr_data_d = lr_wd_i;
      end else if (ctr_we_req_i) begin
        spr_we_d  = 1'b1;
        spr_sel_d = 1'b0;
        spr_wd_d  = ctr_wd_i;
      end else if (lr_we_req_i) begin
        spr_we_d  = 1'b1;
        spr_sel_d = 1'b1;
        spr_wd_d  = lr_wd_i;
      end

      if (br_taken_i) begin
        pc_d    = br_target_i & 32'hFFFF_FFFC;
        flush_d = 1'b1;
        state_d = FLUSH;
      end else begin
        if (!stall_i) begin
          pc_d = pc_q + 32'd4;
        end
        if (ctr_we_req_i && lr_we_req_i) begin
          state_d = HOLD;
        end
      end
    end else begin
      if (lr_pend_q) begin
        spr_we_d  = 1'b1;
        spr_sel_d = 1'b1;
        spr_wd_d  = lr_data_q;
      end
      // PC only moves when the current address was actually fetched.
      case (state_q)
        RUN: begin
          if (!stall_i && !lr_pend_q) begin
            pc_d = pc_q + 32'd4;
          end
        end
        FLUSH:   state_d = RUN;
        HOLD:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      lr_pend_q <= 1'b0;
      lr_data_q <= 32'h0;
      flush_q   <= 1'b0;
      spr_we_q  <= 1'b0;
      spr_sel_q <= 1'b0;
      spr_wd_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      lr_pend_q <= lr_pend_d;
      lr_data_q <= lr_data_d;
      flush_q   <= flush_d;
      spr_we_q  <= spr_we_d;
      spr_sel_q <= spr_sel_d;
      spr_wd_q  <= spr_wd_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
// ============================================================================
// tb_fetch_seq -- directed self-checking bench for fetch_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        br_valid_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        ctr_we_req_i;
  logic [31:0] ctr_wd_i;
  logic        lr_we_req_i;
  logic [31:0] lr_wd_i;
  logic        exc_req_i;
  logic [31:0] pc_o;
  logic        fetch_en_o;
  logic        flush_o;
  logic        spr_we_o;
  logic        spr_sel_o;
  logic [31:0] spr_wd_o;
  logic        busy_o;

  int tests  = 0;
  int failed = 0;

  fetch_seq dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .br_valid_i  (br_valid_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .ctr_we_req_i(ctr_we_req_i),
    .ctr_wd_i    (ctr_wd_i),
    .lr_we_req_i (lr_we_req_i),
    .lr_wd_i     (lr_wd_i),
    .exc_req_i   (exc_req_i),
    .pc_o        (pc_o),
    .fetch_en_o  (fetch_en_o),
    .flush_o     (flush_o),
    .spr_we_o    (spr_we_o),
    .spr_sel_o   (spr_sel_o),
    .spr_wd_o    (spr_wd_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i      = 1'b0;
    br_valid_i   = 1'b0;
    br_taken_i   = 1'b0;
    br_target_i  = 32'h0;
    ctr_we_req_i = 1'b0;
    ctr_wd_i     = 32'h0;
    lr_we_req_i  = 1'b0;
    lr_wd_i      = 32'h0;
    exc_req_i    = 1'b0;
  endtask

  task automatic branch(input logic taken, input logic [31:0] tgt,
                        input logic cwe, input logic [31:0] cwd,
                        input logic lwe, input logic [31:0] lwd);
    br_valid_i   = 1'b1;
    br_taken_i   = taken;
    br_target_i  = tgt;
    ctr_we_req_i = cwe;
    ctr_wd_i     = cwd;
    lr_we_req_i  = lwe;
    lr_wd_i      = lwd;
  endtask

  // Redirect to addr with a taken branch and let the FLUSH cycle pass.
  task automatic goto_pc(input logic [31:0] addr);
    branch(1'b1, addr, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    tests++; if (pc_o !== 32'h0) begin failed++; $display("FAIL rst_pc got %h exp %h", pc_o, 32'h0); end
    tests++; if (fetch_en_o !== 1'b0) begin failed++; $display("FAIL rst_fetch_en got %b exp 0", fetch_en_o); end
    tests++; if (busy_o !== 1'b0) begin failed++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    tests++; if ({flush_o, spr_we_o, spr_sel_o, spr_wd_o} !== 35'h0) begin failed++; $display("FAIL rst_outs got %b%b%b %h exp 000 0", flush_o, spr_we_o, spr_sel_o, spr_wd_o); end
    rst = 1'b0;
    #1;
    tests++; if (pc_o !== 32'h0 || fetch_en_o !== 1'b1) begin failed++; $display("FAIL rel_c0 got pc %h fe %b exp 0 1", pc_o, fetch_en_o); end
    tick();
    tests++; if (pc_o !== 32'h4 || fetch_en_o !== 1'b1) begin failed++; $display("FAIL rel_c1 got pc %h fe %b exp 4 1", pc_o, fetch_en_o); end
    tick();
    tests++; if (pc_o !== 32'h8 || spr_we_o !== 1'b0) begin failed++; $display("FAIL rel_c2 got pc %h we %b exp 8 0", pc_o, spr_we_o); end
  endtask

  task automatic test_taken_ctr();
    goto_pc(32'h100);
    tests++; if (pc_o !== 32'h100) begin failed++; $display("FAIL tk_start got %h exp 100", pc_o); end
    branch(1'b1, 32'h203, 1'b1, 32'h9, 1'b0, 32'h0);
    tick();
    idle_inputs();
    #1;
    tests++; if (pc_o !== 32'h200 || flush_o !== 1'b1) begin failed++; $display("FAIL tk_n1 got pc %h fl %b exp 200 1", pc_o, flush_o); end
    tests++; if (spr_we_o !== 1'b1 || spr_sel_o !== 1'b0 || spr_wd_o !== 32'h9) begin failed++; $display("FAIL tk_n1_spr got %b %b %h exp 1 0 9", spr_we_o, spr_sel_o, spr_wd_o); end
    tests++; if (fetch_en_o !== 1'b0 || busy_o !== 1'b1) begin failed++; $display("FAIL tk_n1_fe got fe %b busy %b exp 0 1", fetch_en_o, busy_o); end
    tick();
    tests++; if (pc_o !== 32'h200 || flush_o !== 1'b0 || fetch_en_o !== 1'b1 || busy_o !== 1'b0) begin failed++; $display("FAIL tk_n2 got pc %h fl %b fe %b busy %b exp 200 0 1 0", pc_o, flush_o, fetch_en_o, busy_o); end
    tests++; if (spr_we_o !== 1'b0 || spr_wd_o !== 32'h9) begin failed++; $display("FAIL tk_n2_spr got we %b wd %h exp 0 9", spr_we_o, spr_wd_o); end
  endtask

  task automatic test_not_taken_dual();
    goto_pc(32'h40);
    branch(1'b0, 32'h0, 1'b1, 32'h5, 1'b1, 32'h44);
    tick();
    // Busy cycle: this branch and the changed lr_wd must both be ignored.
    branch(1'b1, 32'h500, 1'b1, 32'h77, 1'b1, 32'hDEAD);
    #1;
    tests++; if (spr_we_o !== 1'b1 || spr_sel_o !== 1'b0 || spr_wd_o !== 32'h5) begin failed++; $display("FAIL nt_n1_spr got %b %b %h exp 1 0 5", spr_we_o, spr_sel_o, spr_wd_o); end
    tests++; if (fetch_en_o !== 1'b0 || busy_o !== 1'b1 || pc_o !== 32'h44 || flush_o !== 1'b0) begin failed++; $display("FAIL nt_n1 got fe %b busy %b pc %h fl %b exp 0 1 44 0", fetch_en_o, busy_o, pc_o, flush_o); end
    tick();
    idle_inputs();
    #1;
    tests++; if (spr_we_o !== 1'b1 || spr_sel_o !== 1'b1 || spr_wd_o !== 32'h44) begin failed++; $display("FAIL nt_n2_spr got %b %b %h exp 1 1 44", spr_we_o, spr_sel_o, spr_wd_o); end
    tests++; if (pc_o !== 32'h44 || flush_o !== 1'b0) begin failed++; $display("FAIL nt_n2 got pc %h fl %b exp 44 0", pc_o, flush_o); end
    tick();
    tests++; if (fetch_en_o !== 1'b1 || pc_o !== 32'h48) begin failed++; $display("FAIL nt_n3 got fe %b pc %h exp 1 48", fetch_en_o, pc_o); end
    tests++; if (spr_we_o !== 1'b0 || spr_sel_o !== 1'b1 || spr_wd_o !== 32'h44) begin failed++; $display("FAIL nt_n3_hold got %b %b %h exp 0 1 44", spr_we_o, spr_sel_o, spr_wd_o); end
  endtask

  task automatic test_taken_dual();
    goto_pc(32'h1000);
    branch(1'b1, 32'h80, 1'b1, 32'h1, 1'b1, 32'h2);
    tick();
    idle_inputs();
    #1;
    tests++; if (pc_o !== 32'h80 || flush_o !== 1'b1 || spr_we_o !== 1'b1 || spr_sel_o !== 1'b0 || spr_wd_o !== 32'h1) begin failed++; $display("FAIL td_n1 got pc %h fl %b spr %b%b %h exp 80 1 10 1", pc_o, flush_o, spr_we_o, spr_sel_o, spr_wd_o); end
    tick();
    tests++; if (spr_we_o !== 1'b1 || spr_sel_o !== 1'b1 || spr_wd_o !== 32'h2 || flush_o !== 1'b0) begin failed++; $display("FAIL td_n2 got spr %b%b %h fl %b exp 11 2 0", spr_we_o, spr_sel_o, spr_wd_o, flush_o); end
    tests++; if (fetch_en_o !== 1'b1 || busy_o !== 1'b0 || pc_o !== 32'h80) begin failed++; $display("FAIL td_n2_run got fe %b busy %b pc %h exp 1 0 80", fetch_en_o, busy_o, pc_o); end
    tick();
    tests++; if (pc_o !== 32'h84 || spr_we_o !== 1'b0) begin failed++; $display("FAIL td_n3 got pc %h we %b exp 84 0", pc_o, spr_we_o); end
  endtask

  task automatic test_exc_branch();
    goto_pc(32'h2000);
    branch(1'b1, 32'h300, 1'b1, 32'h11, 1'b1, 32'h22);
    exc_req_i = 1'b1;
    tick();
    idle_inputs();
    #1;
    tests++; if (pc_o !== 32'h700 || flush_o !== 1'b1 || spr_we_o !== 1'b0 || busy_o !== 1'b1) begin failed++; $display("FAIL exc_n1 got pc %h fl %b we %b busy %b exp 700 1 0 1", pc_o, flush_o, spr_we_o, busy_o); end
    tick();
    tests++; if (pc_o !== 32'h700 || flush_o !== 1'b0 || spr_we_o !== 1'b0 || fetch_en_o !== 1'b1) begin failed++; $display("FAIL exc_n2 got pc %h fl %b we %b fe %b exp 700 0 0 1", pc_o, flush_o, spr_we_o, fetch_en_o); end
  endtask

  task automatic test_nt_stall();
    goto_pc(32'h3000);
    branch(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    stall_i = 1'b1;
    tick();
    idle_inputs();
    #1;
    tests++; if (pc_o !== 32'h3000 || flush_o !== 1'b0 || busy_o !== 1'b0) begin failed++; $display("FAIL nts got pc %h fl %b busy %b exp 3000 0 0", pc_o, flush_o, busy_o); end
  endtask

  task automatic test_wrap_stall();
    goto_pc(32'hFFFF_FFFC);
    tick();
    tests++; if (pc_o !== 32'h0) begin failed++; $display("FAIL wrap got %h exp 0", pc_o); end
    goto_pc(32'hFFFF_FFFC);
    stall_i = 1'b1;
    #1;
    tests++; if (fetch_en_o !== 1'b0) begin failed++; $display("FAIL stall_c1 got fe %b exp 0", fetch_en_o); end
    tick();
    tests++; if (pc_o !== 32'hFFFF_FFFC || fetch_en_o !== 1'b0) begin failed++; $display("FAIL stall_c2 got pc %h fe %b exp fffffffc 0", pc_o, fetch_en_o); end
    tick();
    tests++; if (pc_o !== 32'hFFFF_FFFC) begin failed++; $display("FAIL stall_c3 got pc %h exp fffffffc", pc_o); end
    stall_i = 1'b0;
    tick();
    tests++; if (pc_o !== 32'h0) begin failed++; $display("FAIL stall_rel got pc %h exp 0", pc_o); end
  endtask

  task automatic test_reset_abandon();
    goto_pc(32'h40);
    branch(1'b0, 32'h0, 1'b1, 32'h5, 1'b1, 32'h44);
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    tests++; if (fetch_en_o !== 1'b0 || busy_o !== 1'b0) begin failed++; $display("FAIL ra_rst got fe %b busy %b exp 0 0", fetch_en_o, busy_o); end
    tick();
    tests++; if (spr_we_o !== 1'b0 || pc_o !== 32'h0 || spr_wd_o !== 32'h0) begin failed++; $display("FAIL ra_n2 got we %b pc %h wd %h exp 0 0 0", spr_we_o, pc_o, spr_wd_o); end
    rst = 1'b0;
    tick();
    tests++; if (spr_we_o !== 1'b0 || pc_o !== 32'h4) begin failed++; $display("FAIL ra_n3 got we %b pc %h exp 0 4", spr_we_o, pc_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_taken_ctr();
    test_not_taken_dual();
    test_taken_dual();
    test_exc_branch();
    test_nt_stall();
    test_wrap_stall();
    test_reset_abandon();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
